// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 8-bit 5-stage pipeline.
// Covers load-use, branch squash, data-memory waits and halt/drain.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             id_rs_a,
  input  logic [2:0]             id_rs_b,
  input  logic                   id_uses_a,
  input  logic                   id_uses_b,
  input  logic                   ex_mem_read,
  input  logic [2:0]             ex_rd,
  input  logic                   ex_branch_taken,
  input  logic                   ex_halt,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   id_ex_en,
  output logic                   ex_mem_en,
  output logic                   mem_wb_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_mem_flush,
  output logic                   mem_wb_flush,
  output logic                   done,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int DW =
    (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam int TW =
    (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(MEM_TIMEOUT);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_MWAIT = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  // {pc,if_id,id_ex,ex_mem,mem_wb en, if_id,id_ex,ex_mem,mem_wb flush}
  localparam logic [8:0] C_NORM = 9'b11111_0000;
  localparam logic [8:0] C_MSTL = 9'b00001_0001;
  localparam logic [8:0] C_HLT  = 9'b01111_1100;
  localparam logic [8:0] C_BR   = 9'b11111_1100;
  localparam logic [8:0] C_LU   = 9'b00111_0100;
  localparam logic [8:0] C_DRS  = 9'b01101_1101;
  localparam logic [8:0] C_OFF  = 9'b00000_0000;

  logic [1:0]    state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [8:0]    ctl;
  logic          mem_stall, load_use;
  logic          sel_mstl, sel_halt, sel_br, sel_lu;
  logic          tmo_hit, run_like;

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ex_mem_read &
    ((id_uses_a & (id_rs_a == ex_rd)) |
     (id_uses_b & (id_rs_b == ex_rd)));

  assign sel_mstl = mem_stall;
  assign sel_halt = ~mem_stall & ex_halt;
  assign sel_br   = ~mem_stall & ~ex_halt & ex_branch_taken;
  assign sel_lu   = ~mem_stall & ~ex_halt & ~ex_branch_taken
                  & load_use;

  assign run_like = (state == S_RUN) | (state == S_MWAIT);

  always_comb begin
    ctl       = C_NORM;
    state_nxt = state;
    drain_nxt = drain_cnt;
    tmo_nxt   = tmo_cnt;
    tmo_hit   = 1'b0;
    unique case (state)
      S_RUN, S_MWAIT: begin
        tmo_nxt   = '0;
        state_nxt = S_RUN;
        unique case (1'b1)
          sel_mstl: begin
            ctl       = C_MSTL;
            state_nxt = S_MWAIT;
            if (state == S_RUN)
              tmo_nxt = TW'(1);
            else if (tmo_cnt >= TMO_MAX)
              tmo_nxt = tmo_cnt;
            else
              tmo_nxt = tmo_cnt + TW'(1);
            tmo_hit = (tmo_nxt >= TMO_MAX);
          end
          sel_halt: begin
            ctl       = C_HLT;
            state_nxt = S_DRAIN;
            drain_nxt = DW'(DRAIN_CYCLES);
          end
          sel_br: ctl = C_BR;
          sel_lu: ctl = C_LU;
          default: ctl = C_NORM;
        endcase
      end
      S_DRAIN: begin
        if (mem_stall) begin
          ctl = C_DRS;
        end else begin
          ctl = C_HLT;
          if (drain_cnt <= DW'(1))
            state_nxt = S_HALT;
          if (drain_cnt != '0)
            drain_nxt = drain_cnt - DW'(1);
        end
      end
      default: ctl = C_OFF;
    endcase
  end

  assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
          if_id_flush, id_ex_flush, ex_mem_flush,
          mem_wb_flush} = reset ? C_OFF : ctl;
  assign done = ~reset & (state == S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RUN;
      drain_cnt <= '0;
      tmo_cnt   <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      tmo_cnt   <= tmo_nxt;
      if (tmo_hit)
        mem_err <= 1'b1;
      if (run_like && !ctl[8] && stall_cnt != '1)
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: per-cycle expected
// control vectors are queued by stimulus and checked by a monitor.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  id_rs_a, id_rs_b, ex_rd;
  logic        id_uses_a, id_uses_b, ex_mem_read;
  logic        ex_branch_taken, ex_halt, mem_req, mem_ready;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic        done, mem_err;
  logic [15:0] stall_cnt;

  localparam logic [8:0] C_NORM = 9'b11111_0000;
  localparam logic [8:0] C_MSTL = 9'b00001_0001;
  localparam logic [8:0] C_HLT  = 9'b01111_1100;
  localparam logic [8:0] C_BR   = 9'b11111_1100;
  localparam logic [8:0] C_LU   = 9'b00111_0100;
  localparam logic [8:0] C_DRS  = 9'b01101_1101;
  localparam logic [8:0] C_OFF  = 9'b00000_0000;

  typedef struct {
    string       name;
    logic [8:0]  ctl;
    logic        done;
    logic        err;
    logic [15:0] sc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  logic [8:0] act;
  int n_chk  = 0;
  int n_pass = 0;

  pipeline_hazard_ctrl #(
    .DRAIN_CYCLES(2),
    .MEM_TIMEOUT(255),
    .STALL_CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
    .id_uses_a(id_uses_a), .id_uses_b(id_uses_b),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_halt(ex_halt),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .done(done), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
      n_chk++;
      if (act === e.ctl && done === e.done &&
          mem_err === e.err && stall_cnt === e.sc)
        n_pass++;
      else
        $display("FAIL %s: got ctl=%b done=%b err=%b sc=%0d want ctl=%b done=%b err=%b sc=%0d",
                 e.name, act, done, mem_err, stall_cnt,
                 e.ctl, e.done, e.err, e.sc);
    end
  end

  task automatic idle();
    id_rs_a = 3'd0; id_rs_b = 3'd0; ex_rd = 3'd0;
    id_uses_a = 1'b0; id_uses_b = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_halt = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic step(input string nm, input logic [8:0] c,
                      input logic d, input logic er,
                      input logic [15:0] sc);
    exp_t x;
    x.name = nm; x.ctl = c; x.done = d; x.err = er; x.sc = sc;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic load_r3();
    ex_mem_read = 1'b1; ex_rd = 3'd3;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    step("reset0", C_OFF, 0, 0, 16'd0);
    step("reset1", C_OFF, 0, 0, 16'd0);
    reset = 1'b0;
    step("run_idle", C_NORM, 0, 0, 16'd0);

    load_r3(); id_rs_a = 3'd3; id_uses_a = 1'b1;
    step("load_use_a", C_LU, 0, 0, 16'd0);
    idle();
    step("after_lu", C_NORM, 0, 0, 16'd1);

    load_r3(); id_rs_a = 3'd3; id_rs_b = 3'd3;
    step("no_use_flags", C_NORM, 0, 0, 16'd1);
    id_uses_b = 1'b1;
    step("load_use_b", C_LU, 0, 0, 16'd1);
    idle();
    step("after_lu_b", C_NORM, 0, 0, 16'd2);

    load_r3(); id_rs_a = 3'd3; id_uses_a = 1'b1;
    ex_branch_taken = 1'b1;
    step("branch_over_lu", C_BR, 0, 0, 16'd2);
    idle();
    step("after_branch", C_NORM, 0, 0, 16'd2);

    mem_req = 1'b1;
    step("mwait1", C_MSTL, 0, 0, 16'd2);
    step("mwait2", C_MSTL, 0, 0, 16'd3);
    step("mwait3", C_MSTL, 0, 0, 16'd4);
    step("mwait4", C_MSTL, 0, 0, 16'd5);
    mem_ready = 1'b1;
    step("mrelease", C_NORM, 0, 0, 16'd6);
    idle();
    step("after_mrel", C_NORM, 0, 0, 16'd6);

    mem_req = 1'b1;
    step("mwait_lu", C_MSTL, 0, 0, 16'd6);
    mem_ready = 1'b1;
    load_r3(); id_rs_b = 3'd3; id_uses_b = 1'b1;
    step("release_lu", C_LU, 0, 0, 16'd7);
    idle();
    step("after_rel_lu", C_NORM, 0, 0, 16'd8);

    ex_halt = 1'b1;
    step("halt", C_HLT, 0, 0, 16'd8);
    idle();
    step("drain0", C_HLT, 0, 0, 16'd9);
    mem_req = 1'b1;
    step("drain_stall", C_DRS, 0, 0, 16'd9);
    idle();
    step("drain2", C_HLT, 0, 0, 16'd9);
    step("halted", C_OFF, 1, 0, 16'd9);
    ex_branch_taken = 1'b1; mem_req = 1'b1;
    step("halted_hold", C_OFF, 1, 0, 16'd9);
    idle();
    reset = 1'b1;
    step("reset_halted", C_OFF, 0, 0, 16'd9);
    reset = 1'b0;
    step("run_after_rst", C_NORM, 0, 0, 16'd0);

    mem_req = 1'b1;
    for (int k = 1; k <= 258; k++)
      step($sformatf("tmo%0d", k), C_MSTL, 0, (k >= 256),
           16'(k - 1));
    mem_ready = 1'b1;
    step("tmo_release", C_NORM, 0, 1, 16'd258);
    idle();
    step("err_sticky", C_NORM, 0, 1, 16'd258);
    reset = 1'b1;
    step("err_in_rst", C_OFF, 0, 1, 16'd258);
    reset = 1'b0;
    step("err_cleared", C_NORM, 0, 0, 16'd0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++)
      @(posedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_queue: %0d left want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 8-bit 5-stage pipeline.
- Drives per-stage enable/flush to the PC and to the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
- Handles load-use stalls, taken-branch squash, variable-latency data-memory waits and a halt/drain sequence.
- Control outputs are combinational from registered state plus current inputs; state, drain counter, timeout and stall counter are registered.

Parameters:
- DRAIN_CYCLES, 2, cycles EX_MEM/MEM_WB keep advancing after a halt before done.
- MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before mem_err sets.
- STALL_CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- id_rs_a  in  3  source register A of the instruction in ID.
- id_rs_b  in  3  source register B of the instruction in ID.
- id_uses_a  in  1  ID instruction reads rs_a.
- id_uses_b  in  1  ID instruction reads rs_b.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  3  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- ex_halt  in  1  halt instruction in EX.
- mem_req  in  1  instruction in MEM accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables (0 = hold).
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble (all-zero control); flush overrides en.
- done  out  1  pipeline halted and drained.
- mem_err  out  1  sticky memory timeout flag.
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with pc_en=0 in RUN/MEM_WAIT.

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALTED. On reset: state=RUN, counters=0, mem_err=0, stall_cnt=0.
- While reset=1, all en=0, all flush=0, done=0.
- mem_stall = mem_req & ~mem_ready. load_use = ex_mem_read & ((id_uses_a & id_rs_a==ex_rd) | (id_uses_b & id_rs_b==ex_rd)).
- RUN priority 1, mem_stall: pc/if_id/id_ex/ex_mem en=0, mem_wb_flush=1. Next state MEM_WAIT, timeout counter=1. Branch/halt/load_use are ignored this cycle; they re-evaluate when released because the stages hold.
- RUN priority 2, ex_halt: pc_en=0, if_id_flush=1, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. Next state DRAIN, drain counter=DRAIN_CYCLES.
- RUN priority 3, ex_branch_taken: all en=1, if_id_flush=1, id_ex_flush=1. Branch beats load_use because the stalled instruction is wrong-path.
- RUN priority 4, load_use: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1. This gives exactly one bubble: the next cycle the load has left EX.
- RUN otherwise: all en=1, all flush=0.
- MEM_WAIT: same outputs as the RUN mem_stall case while mem_stall holds; the timeout counter increments, saturating.
  - When the counter reaches MEM_TIMEOUT, mem_err sets; mem_err clears only on reset.
  - The cycle mem_ready=1: all en=1, normal advance, and return to RUN.
  - Hazards in that release cycle are re-evaluated as in RUN priorities 2-4, using the same cycle's inputs.
- DRAIN: pc_en=0, if_id_flush=id_ex_flush=1. While mem_stall: ex_mem_en=0, mem_wb_flush=1, counter paused. Otherwise ex_mem_en=mem_wb_en=1 and the counter decrements. At 0 go to HALTED.
- HALTED: all en=0, flush=0, done=1. Leave only via reset.
- stall_cnt: +1 each cycle pc_en=0 in RUN or MEM_WAIT, saturating at all-ones. DRAIN/HALTED cycles are not counted.

Test Plan:
- Load r3 in EX, ID reads rs_a=3, id_uses_a=1 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all en=1; stall_cnt=1.
- Same as above but id_uses_a=0 and rs_b=3 with id_uses_b=0 -> no stall, all en=1.
- ex_branch_taken=1 with load_use also true -> if_id_flush=id_ex_flush=1, pc_en=1, stall_cnt unchanged.
- mem_req=1, mem_ready low for 4 cycles then high -> 4 cycles frozen with mem_wb_flush=1, release on 5th cycle, stall_cnt=4.
- mem_req=1, mem_ready never high, MEM_TIMEOUT=255 -> mem_err=1 after cycle 255 and stays set; reset clears it and returns to RUN.
- ex_halt=1, DRAIN_CYCLES=2, one mem_stall cycle mid-drain -> done=1 exactly 3 cycles after DRAIN entry; pc_en=0 thereafter until reset.
